// File: rtl/temp_conv_pipe_pkg.sv
// Shared constants and mode encoding for the temperature conversion pipeline.
package temp_conv_pipe_pkg;

  typedef enum logic {
    MODE_C2F = 1'b0,
    MODE_F2C = 1'b1
  } mode_e;

  localparam int unsigned OFFSET_F = 32;
  localparam int unsigned MUL_C2F  = 9;
  localparam int unsigned DIV_C2F  = 5;
  localparam int unsigned MUL_F2C  = 5;
  localparam int unsigned DIV_F2C  = 9;

endpackage

// File: rtl/temp_conv_pipe_if.sv
// Sample-in / result-out streaming bus for temp_conv_pipe.
interface temp_conv_pipe_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 10,
  parameter int CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (
    output in_valid, in_data, in_ch, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/temp_conv_stats.sv
// Per-channel min/max/alarm register file, updated on each result transfer.
module temp_conv_stats #(
  parameter int OUT_W  = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_en,
  input  logic [CH_W-1:0]   upd_ch,
  input  logic [OUT_W-1:0]  upd_data,
  input  logic [OUT_W-1:0]  thresh,
  input  logic [NUM_CH-1:0] alarm_clr,
  output logic [NUM_CH-1:0] alarm,
  input  logic [CH_W-1:0]   stat_ch,
  output logic [OUT_W-1:0]  stat_min,
  output logic [OUT_W-1:0]  stat_max
);

  logic [OUT_W-1:0] min_r [NUM_CH];
  logic [OUT_W-1:0] max_r [NUM_CH];

  // Tags >= NUM_CH never match any index, so they leave the file untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        min_r[c] <= '1;
        max_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (upd_en && upd_ch == CH_W'(c)) begin
          if (upd_data < min_r[c]) min_r[c] <= upd_data;
          if (upd_data > max_r[c]) max_r[c] <= upd_data;
        end
        if (upd_en && upd_ch == CH_W'(c) && upd_data > thresh) alarm[c] <= 1'b1;
        else if (alarm_clr[c])                                  alarm[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    stat_min = '1;
    stat_max = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (stat_ch == CH_W'(c)) begin
        stat_min = min_r[c];
        stat_max = max_r[c];
      end
    end
  end

endmodule

// File: rtl/temp_conv_pipe.sv
// Two-stage stallable C<->F converter with per-channel statistics and alarms.
module temp_conv_pipe
  import temp_conv_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  temp_conv_pipe_if.slave   bus,
  input  logic [OUT_W-1:0]  thresh,
  output logic [NUM_CH-1:0] alarm,
  input  logic [NUM_CH-1:0] alarm_clr,
  input  logic [CH_W-1:0]   stat_ch,
  output logic [OUT_W-1:0]  stat_min,
  output logic [OUT_W-1:0]  stat_max
);

  localparam int P_W = DATA_W + 4;
  localparam logic [DATA_W-1:0] OFF_D     = DATA_W'(OFFSET_F);
  localparam logic [P_W-1:0]    OFF_P     = P_W'(OFFSET_F);
  localparam logic [P_W-1:0]    MUL_C2F_P = P_W'(MUL_C2F);
  localparam logic [P_W-1:0]    DIV_C2F_P = P_W'(DIV_C2F);
  localparam logic [P_W-1:0]    MUL_F2C_P = P_W'(MUL_F2C);
  localparam logic [P_W-1:0]    DIV_F2C_P = P_W'(DIV_F2C);

  logic             advance;
  mode_e            in_mode;
  logic [P_W-1:0]   p_next;
  logic [P_W-1:0]   r_full;

  logic             s1_valid;
  logic [P_W-1:0]   s1_p;
  mode_e            s1_mode;
  logic [CH_W-1:0]  s1_ch;

  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;
  logic [CH_W-1:0]  s2_ch;

  assign advance      = !s2_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign in_mode      = mode_e'(bus.in_mode);

  // Multiply first, divide in the next stage, so truncation only happens once.
  always_comb begin
    p_next = '0;
    if (in_mode == MODE_F2C) begin
      if (bus.in_data >= OFF_D) p_next = P_W'(bus.in_data - OFF_D) * MUL_F2C_P;
    end else begin
      p_next = P_W'(bus.in_data) * MUL_C2F_P;
    end
  end

  always_comb begin
    if (s1_mode == MODE_F2C) r_full = s1_p / DIV_F2C_P;
    else                     r_full = s1_p / DIV_C2F_P + OFF_P;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_mode  <= MODE_C2F;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ch    <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_p     <= p_next;
      s1_mode  <= in_mode;
      s1_ch    <= bus.in_ch;
      s2_valid <= s1_valid;
      s2_data  <= OUT_W'(r_full);
      s2_ch    <= s1_ch;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ch    = s2_ch;

  temp_conv_stats #(
    .OUT_W  (OUT_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (s2_valid && bus.out_ready),
    .upd_ch    (s2_ch),
    .upd_data  (s2_data),
    .thresh    (thresh),
    .alarm_clr (alarm_clr),
    .alarm     (alarm),
    .stat_ch   (stat_ch),
    .stat_min  (stat_min),
    .stat_max  (stat_max)
  );

endmodule
